// File: rtl/vstreamout_sched_pkg.sv
// Shared definitions for the vector-stream-out scheduler: stream geometry, FSM encoding
// and the round-robin arbiter result type.
package vstreamout_sched_pkg;

  localparam int unsigned phit_size    = 32;
  localparam int unsigned SIMD_degree  = 4;
  localparam int unsigned header_bytes = 8;

  typedef logic [2:0] sched_state_t;

  localparam sched_state_t ST_IDLE   = 3'd0;
  localparam sched_state_t ST_SETUP  = 3'd1;
  localparam sched_state_t ST_HDR    = 3'd2;
  localparam sched_state_t ST_STREAM = 3'd3;
  localparam sched_state_t ST_GAP    = 3'd4;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } rr_arb_t;

endpackage

// File: rtl/vstreamout_sched_if.sv
// Bundle of request, source-stream and assembler-side signals for the scheduler.
interface vstreamout_sched_if #(
  parameter int unsigned NUM_REQ = 4
) ();
  import vstreamout_sched_pkg::*;

  logic [NUM_REQ-1:0]                  req;
  logic [NUM_REQ-1:0][15:0]            req_len;
  logic [NUM_REQ-1:0][phit_size-1:0]   src_tdata;
  logic [NUM_REQ-1:0][SIMD_degree-1:0] src_tvalid;
  logic [NUM_REQ-1:0][SIMD_degree-1:0] src_tlast;
  logic [NUM_REQ-1:0]                  src_ready;
  logic [NUM_REQ-1:0]                  grant;
  logic                                is_spl;
  logic [31:0]                         spl_len;
  logic                                is_vstreamout_global;
  logic                                is_header;
  logic [phit_size-1:0]                tdata_out;
  logic [SIMD_degree-1:0]              tvalid_out;
  logic [SIMD_degree-1:0]              tlast_out;
  logic                                err_timeout;
  logic [15:0]                         pkt_cnt;

  // Sources and the assembler side, as seen from outside the scheduler.
  modport master (
    output req, req_len, src_tdata, src_tvalid, src_tlast,
    input  src_ready, grant, is_spl, spl_len, is_vstreamout_global, is_header,
    input  tdata_out, tvalid_out, tlast_out, err_timeout, pkt_cnt
  );

  modport slave (
    input  req, req_len, src_tdata, src_tvalid, src_tlast,
    output src_ready, grant, is_spl, spl_len, is_vstreamout_global, is_header,
    output tdata_out, tvalid_out, tlast_out, err_timeout, pkt_cnt
  );

endinterface

// File: rtl/vstreamout_sched_rr_arb.sv
// Combinational round-robin pick: lowest requesting index at or after rr_ptr, else lowest overall.
module vstreamout_sched_rr_arb
  import vstreamout_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [3:0]         rr_ptr,
  output rr_arb_t            pick
);

  always_comb begin
    pick = '0;
    // Descending scans so the last hit is the lowest index; the second pass overrides the wrap case.
    for (int j = int'(NUM_REQ) - 1; j >= 0; j--) begin
      if (req[j]) begin
        pick.valid = 1'b1;
        pick.idx   = 4'(j);
      end
    end
    for (int j = int'(NUM_REQ) - 1; j >= 0; j--) begin
      if (req[j] && (4'(j) >= rr_ptr)) begin
        pick.idx = 4'(j);
      end
    end
  end

endmodule

// File: rtl/vstreamout_sched.sv
// Round-robin scheduler sharing one packet assembler between NUM_REQ vector-stream-out sources;
// holds a guard gap after each packet so the assembler checksum pipeline drains.
module vstreamout_sched
  import vstreamout_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned HDR_LAT = 6,
  parameter int unsigned TIMEOUT = 1024
) (
  input logic               clk,
  input logic               rst_n,
  vstreamout_sched_if.slave bus
);

  localparam int unsigned CntMax = (TIMEOUT > HDR_LAT) ? TIMEOUT : HDR_LAT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  sched_state_t           state_q, state_d;
  logic [3:0]             win_q, win_d;
  logic [3:0]             rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [31:0]            spl_len_q, spl_len_d;
  logic                   is_spl_q, is_spl_d;
  logic                   hdr_q, hdr_d;
  logic                   err_q, err_d;
  logic [15:0]            pkt_q, pkt_d;
  logic [phit_size-1:0]   tdata_q, tdata_d;
  logic [SIMD_degree-1:0] tvalid_q, tvalid_d;
  logic [SIMD_degree-1:0] tlast_q, tlast_d;

  rr_arb_t                pick;
  logic [phit_size-1:0]   sel_data;
  logic [SIMD_degree-1:0] sel_valid, sel_last;
  logic                   active, beat_ok, beat_last;

  vstreamout_sched_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arb (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .pick   (pick)
  );

  always_comb begin
    sel_data  = '0;
    sel_valid = '0;
    sel_last  = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (win_q == 4'(j)) begin
        sel_data  = bus.src_tdata[j];
        sel_valid = bus.src_tvalid[j];
        sel_last  = bus.src_tlast[j];
      end
    end
  end

  assign active    = (state_q == ST_HDR) || (state_q == ST_STREAM);
  assign beat_ok   = |sel_valid;
  assign beat_last = |(sel_valid & sel_last);

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    spl_len_d = spl_len_q;
    is_spl_d  = 1'b0;
    hdr_d     = 1'b0;
    err_d     = err_q;
    pkt_d     = pkt_q;
    tdata_d   = '0;
    tvalid_d  = '0;
    tlast_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick.valid) begin
          win_d    = pick.idx;
          grant_d  = '0;
          for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (pick.idx == 4'(j)) begin
              grant_d[j] = 1'b1;
              spl_len_d  = {16'h0000, bus.req_len[j]};
            end
          end
          is_spl_d = 1'b1;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_HDR;
      end
      ST_HDR, ST_STREAM: begin
        if (beat_ok) begin
          tdata_d  = sel_data;
          tvalid_d = sel_valid;
          tlast_d  = sel_last;
          hdr_d    = (state_q == ST_HDR);
          cnt_d    = '0;
          state_d  = beat_last ? ST_GAP : ST_STREAM;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          // Abort: the packet is closed through the normal guard gap.
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == CntW'(HDR_LAT - 1)) begin
          cnt_d    = '0;
          rr_ptr_d = (win_q == 4'(NUM_REQ - 1)) ? 4'd0 : win_q + 4'd1;
          pkt_d    = pkt_q + 16'd1;
          grant_d  = '0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      win_q     <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      spl_len_q <= '0;
      is_spl_q  <= 1'b0;
      hdr_q     <= 1'b0;
      err_q     <= 1'b0;
      pkt_q     <= '0;
      tdata_q   <= '0;
      tvalid_q  <= '0;
      tlast_q   <= '0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      spl_len_q <= spl_len_d;
      is_spl_q  <= is_spl_d;
      hdr_q     <= hdr_d;
      err_q     <= err_d;
      pkt_q     <= pkt_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
    end
  end

  assign bus.src_ready            = active ? grant_q : '0;
  assign bus.grant                = grant_q;
  assign bus.is_spl               = is_spl_q;
  assign bus.spl_len              = spl_len_q;
  assign bus.is_vstreamout_global = hdr_q;
  assign bus.is_header            = hdr_q;
  assign bus.tdata_out            = tdata_q;
  assign bus.tvalid_out           = tvalid_q;
  assign bus.tlast_out            = tlast_q;
  assign bus.err_timeout          = err_q;
  assign bus.pkt_cnt              = pkt_q;

endmodule

// File: tb/tb_vstreamout_sched.sv
// Directed + randomized bench for vstreamout_sched against a transaction-level reference model.
module tb_vstreamout_sched;
  import vstreamout_sched_pkg::*;

  localparam int NR = 4;
  localparam int HL = 6;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vstreamout_sched_if #(.NUM_REQ(NR)) bus ();

  vstreamout_sched #(
    .NUM_REQ (NR),
    .HDR_LAT (HL),
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          cur_w = -1;
  int          ptr_m = 0;
  int          last_src = -1;
  logic [15:0] pkt_m = 16'd0;
  bit          err_m = 1'b0;
  logic [15:0] len_m [NR];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sources other than the current owner present random garbage every cycle.
  task automatic tick();
    for (int i = 0; i < NR; i++) begin
      if (i != cur_w) begin
        bus.src_tdata[i]  = $urandom;
        bus.src_tvalid[i] = 4'($urandom);
        bus.src_tlast[i]  = 4'($urandom);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int pick_m(input logic [NR-1:0] r);
    for (int k = 0; k < NR; k++) begin
      if (r[(ptr_m + k) % NR]) return (ptr_m + k) % NR;
    end
    return -1;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_grant"}, bus.grant, 0);
    chk({tag, "_src_ready"}, bus.src_ready, 0);
    chk({tag, "_is_spl"}, bus.is_spl, 0);
    chk({tag, "_spl_len"}, bus.spl_len, 0);
    chk({tag, "_global"}, bus.is_vstreamout_global, 0);
    chk({tag, "_header"}, bus.is_header, 0);
    chk({tag, "_tdata"}, bus.tdata_out, 0);
    chk({tag, "_tvalid"}, bus.tvalid_out, 0);
    chk({tag, "_tlast"}, bus.tlast_out, 0);
    chk({tag, "_err"}, bus.err_timeout, 0);
    chk({tag, "_pkt_cnt"}, bus.pkt_cnt, 0);
  endtask

  // One full packet: grant, header, payload (with optional pre-delay and mid bubble) or
  // abort via timeout, then the guard gap. Called in the IDLE cycle.
  task automatic serve(input logic [NR-1:0] reqs, input int nbeats, input int pre_in,
                       input int bub, input bit abort, input int fixlen);
    int w, sent, idle, bl, pre;
    bit beat, last, done;
    logic [3:0] vl, ll;
    logic [31:0] d;
    pre = pre_in;
    for (int i = 0; i < NR; i++) begin
      len_m[i] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
    end
    w = pick_m(reqs);
    if (fixlen >= 0) len_m[w] = 16'(fixlen);
    for (int i = 0; i < NR; i++) bus.req_len[i] = len_m[i];
    bus.req = reqs;
    tick();
    chk("grant", bus.grant, 64'(1 << w));
    chk("is_spl", bus.is_spl, 1);
    chk("spl_len", bus.spl_len, {16'h0000, len_m[w]});
    if (last_src >= 0) chk("spl_spacing", cyc - last_src, HL + 2);
    bus.req[w] = 1'b0;
    tick();
    chk("is_spl_pulse", bus.is_spl, 0);
    sent = 0; idle = 0; bl = bub; done = 1'b0; cur_w = w;
    for (int n = 0; n < 200 && !done; n++) begin
      if (sent == 0 && pre > 0) begin
        beat = 1'b0; pre--;
      end else if (sent == 1 && (abort || bl > 0)) begin
        beat = 1'b0; if (bl > 0) bl--;
      end else begin
        beat = 1'b1;
      end
      last = beat && (sent + 1 == nbeats);
      d = $urandom;
      if (beat) begin
        vl = 4'($urandom_range(1, 15));
        ll = 4'($urandom) & ~vl;
        if (last) ll = ll | (vl & (~vl + 4'd1));
      end else begin
        vl = 4'h0;
        ll = 4'($urandom);
      end
      bus.src_tdata[w]  = d;
      bus.src_tvalid[w] = vl;
      bus.src_tlast[w]  = ll;
      chk("src_ready", bus.src_ready, 64'(1 << w));
      if (beat) sent++;
      tick();
      chk("tvalid_out", bus.tvalid_out, vl);
      if (beat) begin
        chk("tdata_out", bus.tdata_out, d);
        chk("tlast_out", bus.tlast_out, ll);
        chk("is_header", bus.is_header, sent == 1);
        chk("is_global", bus.is_vstreamout_global, sent == 1);
        idle = 0;
      end else begin
        chk("is_header_idle", bus.is_header, 0);
        idle++;
      end
      if (last) begin
        last_src = cyc - 1;
        done = 1'b1;
      end else if (abort && idle == TO - 1) begin
        chk("err_before_timeout", bus.err_timeout, err_m);
      end else if (abort && idle == TO) begin
        err_m = 1'b1;
        chk("err_timeout", bus.err_timeout, 1);
        last_src = cyc - 1;
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $error("FAIL packet_bound: observed no packet end expected end within 200 cycles");
    end
    cur_w = -1;
    chk("ready_gap", bus.src_ready, 0);
    for (int k = 1; k < HL; k++) begin
      tick();
      chk("grant_hold", bus.grant, 64'(1 << w));
      chk("gap_tvalid", bus.tvalid_out, 0);
    end
    tick();
    pkt_m = pkt_m + 16'd1;
    ptr_m = (w + 1) % NR;
    chk("grant_clear", bus.grant, 0);
    chk("pkt_cnt", bus.pkt_cnt, pkt_m);
    chk("err_sticky", bus.err_timeout, err_m);
  endtask

  initial begin
    int rw;
    bus.req        = '0;
    bus.req_len    = '0;
    bus.src_tdata  = '0;
    bus.src_tvalid = '0;
    bus.src_tlast  = '0;
    rst_n = 1'b0;
    repeat (2) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    serve(4'b0001, 3, 0, 0, 1'b0, 64);  // single packet, length 64
    serve(4'b0010, 1, 0, 0, 1'b0, -1);  // single-beat packet
    serve(4'b0010, 1, 0, 0, 1'b0, 0);   // same source back-to-back, zero length
    serve(4'b1000, 4, 2, 5, 1'b0, -1);  // bubbles before header and mid-stream
    serve(4'b0101, 3, 0, 0, 1'b1, -1);  // timeout abort
    serve(4'b0101, 2, 0, 0, 1'b0, -1);  // next requester served after abort

    // Reset in the middle of a packet.
    bus.req = 4'b0100;
    rw = pick_m(bus.req);
    tick();
    tick();
    cur_w = rw;
    for (int k = 0; k < 2; k++) begin
      bus.src_tdata[rw]  = $urandom;
      bus.src_tvalid[rw] = 4'hF;
      bus.src_tlast[rw]  = 4'h0;
      tick();
    end
    chk("pre_reset_beat", bus.tvalid_out, 4'hF);
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    ptr_m = 0; pkt_m = 16'd0; err_m = 1'b0; last_src = -1; cur_w = -1;
    bus.req = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // All sources requesting: strict rotation starting at source 0.
    for (int p = 0; p < 8; p++) begin
      serve(4'b1111, $urandom_range(1, 4), $urandom_range(0, 2), $urandom_range(0, 3),
            1'b0, -1);
    end

    for (int p = 0; p < 12; p++) begin
      serve(4'($urandom_range(1, 15)), $urandom_range(1, 5), $urandom_range(0, 2),
            $urandom_range(0, 3), 1'b0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
